multi_push_fifo: RTL and testbench
==================================

Name: multi_push_fifo

Overview:
- Circular-buffer FIFO accepting up to PUSH_LANES writes per cycle and one read per cycle.
- FWFT read side: pop_data is valid whenever empty is low.
- Used where several producers (e.g. parallel clause evaluators emitting implied literals) must enqueue in the same cycle into one ordered queue drained by a single consumer.
- Extends the single-push sfifo with multi-lane compaction, all-or-nothing backpressure, almost-full and free-slot status.

Parameters:
- WIDTH, 32, payload bits per entry.
- DEPTH, 64, number of entries; must be a power of two and >= PUSH_LANES.
- PUSH_LANES, 4, write lanes per cycle; must be >= 1.
- AFULL_THRESH, DEPTH-2*PUSH_LANES, almost_full asserts when count >= AFULL_THRESH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- push_valid  in  PUSH_LANES  per-lane write request.
- push_data  in  PUSH_LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- push_ready  out  1  high when free_slots >= PUSH_LANES.
- pop  in  1  consume head entry.
- pop_data  out  WIDTH  head entry, combinational mem[rd_ptr].
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AFULL_THRESH.
- count  out  $clog2(DEPTH)+1  entries stored.
- free_slots  out  $clog2(DEPTH)+1  DEPTH - count.
- flush  in  1  synchronous clear; highest priority below reset.

Behaviour:
- Reset (async, rst_n low): wr_ptr=0, rd_ptr=0, cnt=0. Outputs: empty=1, full=0, almost_full=(AFULL_THRESH==0), push_ready=1, count=0, free_slots=DEPTH. Memory contents are not reset; pop_data is undefined while empty.
- Push fire: push_ready && |push_valid.
  - Valid lanes are compacted in ascending lane index: the k-th set lane is written to mem[(wr_ptr+k) mod DEPTH].
  - wr_ptr advances by popcount(push_valid); the pointer wraps naturally at width $clog2(DEPTH).
  - Invalid lanes are skipped and leave no gap.
- Backpressure is all-or-nothing. If push_ready=0, no lane is written, even if enough space exists for a subset. The producer holds its data.
- push_ready is computed from the current count only. A same-cycle pop does not raise it. No combinational path from pop to push_ready.
- Pop fire: pop && !empty. rd_ptr advances by 1 with wrap. A pop while empty is ignored, with no state change.
- Count update: cnt_next = cnt + popcount(accepted lanes) - pop_fire. Compute at $clog2(DEPTH)+2 bits internally, then truncate. No overflow is possible given the push_ready rule.
- Simultaneous push and pop:
  - Both take effect.
  - Pop on an empty FIFO with a same-cycle push is ignored; the new data appears at pop_data the next cycle.
  - Full FIFO: push_ready=0, so a pop yields cnt=DEPTH-1.
- Latency: a pushed entry is visible at pop_data one cycle after the push edge if it is the new head.
- flush: the next edge sets pointers and cnt to 0. Pushes and pops in the same cycle are discarded.
- Reset mid-operation: immediate clear regardless of clock; in-flight pushes are lost.

Optional Feature:
- Macro: MULTI_PUSH_FIFO_OVF_CNT_EN.
- When defined:
  - Adds output ovf_cnt [15:0], a saturating count of lanes offered while push_ready=0. It increments by popcount(push_valid) per cycle and saturates at 16'hFFFF.
  - Adds output ovf_sticky, set on the first such cycle.
  - Both are cleared by reset and by flush.
- When undefined: neither port nor logic exists; behaviour is otherwise identical.

Decomposition:
- Package fifo_pkg holds:
  - function popcount_lanes(logic [PUSH_LANES-1:0]) returning a count-width value;
  - localparam helper for count width, $clog2(DEPTH)+1;
  - the OVF_CNT_W=16 constant.
- Sub-module push_compactor: purely combinational. It takes push_valid and produces per-lane write offset (prefix popcount) and total accepted count. It is instantiated once.
- Pointer, count and memory logic stay in multi_push_fifo.

Test Plan:
- Reset then idle, DEPTH=64, PUSH_LANES=4 -> empty=1, count=0, free_slots=64, push_ready=1.
- push_valid=4'b1011 with data A,B,-,D, then pop x3 -> pop_data sequence A,B,D; count 3->0; empty=1 after the third pop.
- Fill to count=61, then push_valid=4'b0001 -> push_ready=0 at count 61, no write, count stays 61. Pop once and push 1 the next cycle -> push_ready=1 only when count<=60.
- Wrap-around: advance pointers to wr_ptr=62, push 4 lanes W,X,Y,Z -> stored at slots 62,63,0,1; wr_ptr=2; pops return W,X,Y,Z in order.
- Same-cycle push of 2 lanes and pop at count=10 -> count=11. With flush asserted in the same cycle -> count=0, empty=1, no data retained.
- With MULTI_PUSH_FIFO_OVF_CNT_EN: at full, push_valid=4'b1111 held 3 cycles -> ovf_cnt=12, ovf_sticky=1. Flush -> both 0.

Source files
------------

// File: rtl/multi_push_fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the multi-lane push FIFO.
//   OVF_CNT_W      : width of the optional overflow-lane counter
//   MAX_LANES      : widest push_valid vector the popcount helper accepts
//   LANE_CNT_W     : width of a popcount over MAX_LANES lanes
//   cnt_width()    : occupancy counter width for a given depth ($clog2(depth)+1)
//   popcount_lanes : number of set lanes in a (zero-extended) push_valid vector
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int OVF_CNT_W  = 16;
    localparam int MAX_LANES  = 32;
    localparam int LANE_CNT_W = $clog2(MAX_LANES) + 1;

    // One extra bit so that a completely full FIFO (count == depth) is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [LANE_CNT_W-1:0] popcount_lanes(input logic [MAX_LANES-1:0] lanes);
        logic [LANE_CNT_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            sum = sum + LANE_CNT_W'(lanes[i]);
        end
        return sum;
    endfunction

endpackage

// File: rtl/multi_push_fifo_if.sv
// -----------------------------------------------------------------------------
// multi_push_fifo_if
// Bundles the push, pop, flush and status signals of multi_push_fifo.
//   master : producer/consumer side (drives push_valid, push_data, pop, flush)
//   slave  : FIFO side (drives push_ready, pop_data and all status outputs)
// Optional signals ovf_cnt / ovf_sticky exist only when
// MULTI_PUSH_FIFO_OVF_CNT_EN is defined.
// -----------------------------------------------------------------------------
interface multi_push_fifo_if
    import fifo_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 64,
    parameter int PUSH_LANES = 4
);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [PUSH_LANES-1:0]       push_valid;
    logic [PUSH_LANES*WIDTH-1:0] push_data;
    logic                        push_ready;
    logic                        pop;
    logic [WIDTH-1:0]            pop_data;
    logic                        empty;
    logic                        full;
    logic                        almost_full;
    logic [CNT_W-1:0]            count;
    logic [CNT_W-1:0]            free_slots;
    logic                        flush;
`ifdef MULTI_PUSH_FIFO_OVF_CNT_EN
    logic [OVF_CNT_W-1:0]        ovf_cnt;
    logic                        ovf_sticky;
`endif

    modport master (
        output push_valid, push_data, pop, flush,
        input  push_ready, pop_data, empty, full, almost_full, count, free_slots
`ifdef MULTI_PUSH_FIFO_OVF_CNT_EN
        , input ovf_cnt, ovf_sticky
`endif
    );

    modport slave (
        input  push_valid, push_data, pop, flush,
        output push_ready, pop_data, empty, full, almost_full, count, free_slots
`ifdef MULTI_PUSH_FIFO_OVF_CNT_EN
        , output ovf_cnt, ovf_sticky
`endif
    );

endinterface

// File: rtl/multi_push_fifo_push_compactor.sv
// -----------------------------------------------------------------------------
// push_compactor
// Purely combinational lane compaction for multi_push_fifo.
//   push_valid : per-lane write request
//   offset[i]  : number of valid lanes below lane i (write slot relative to wr_ptr)
//   total      : number of valid lanes
// -----------------------------------------------------------------------------
module push_compactor
    import fifo_pkg::*;
#(
    parameter int PUSH_LANES = 4,
    parameter int OFS_W      = $clog2(PUSH_LANES + 1)
) (
    input  logic [PUSH_LANES-1:0]            push_valid,
    output logic [PUSH_LANES-1:0][OFS_W-1:0] offset,
    output logic [OFS_W-1:0]                 total
);

    // Exclusive prefix popcount: lane i lands after every valid lane below it,
    // so invalid lanes leave no gap in the buffer.
    always_comb begin
        logic [OFS_W-1:0] running;
        // NOTE: every always_comb output and temporary gets a default before any
        // conditional logic, so no path leaves a value held and no latch is inferred.
        running = '0;
        offset  = '0;
        for (int i = 0; i < PUSH_LANES; i++) begin
            offset[i] = running;
            running   = running + OFS_W'(push_valid[i]);
        end
    end

    assign total = OFS_W'(popcount_lanes(MAX_LANES'(push_valid)));

endmodule

// File: rtl/multi_push_fifo.sv
// -----------------------------------------------------------------------------
// multi_push_fifo
// Circular-buffer FIFO with up to PUSH_LANES compacted writes and one FWFT read
// per cycle. Pushes are all-or-nothing: a push is accepted only when at least
// PUSH_LANES slots are free, judged from the current count alone.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : multi_push_fifo_if.slave
//       push_valid/push_data/push_ready : multi-lane write side
//       pop/pop_data                    : FWFT read side (pop_data = head)
//       flush                           : synchronous clear, beats push/pop
//       empty/full/almost_full/count/free_slots : occupancy status
// Optional feature (macro MULTI_PUSH_FIFO_OVF_CNT_EN): ovf_cnt counts lanes
// offered while push_ready is low (saturating), ovf_sticky flags any such cycle.
// -----------------------------------------------------------------------------
module multi_push_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 64,
    parameter int PUSH_LANES   = 4,
    parameter int AFULL_THRESH = DEPTH - 2 * PUSH_LANES
) (
    input logic              clk,
    input logic              rst_n,
    multi_push_fifo_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam int OFS_W = $clog2(PUSH_LANES + 1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    logic [PUSH_LANES-1:0][OFS_W-1:0] lane_offset;
    logic [OFS_W-1:0]                 lane_total;

    logic             push_ready;
    logic             push_fire;
    logic             pop_fire;
    logic             empty;
    logic [CNT_W-1:0] free_slots;
    logic [OFS_W-1:0] accepted;
    logic [CNT_W:0]   cnt_wide;

    push_compactor #(
        .PUSH_LANES (PUSH_LANES),
        .OFS_W      (OFS_W)
    ) u_compactor (
        .push_valid (bus.push_valid),
        .offset     (lane_offset),
        .total      (lane_total)
    );

    // push_ready depends on cnt only, so a same-cycle pop never feeds back into it.
    assign free_slots = CNT_W'(DEPTH) - cnt;
    assign push_ready = (free_slots >= CNT_W'(PUSH_LANES));
    assign empty      = (cnt == '0);
    assign push_fire  = push_ready && (|bus.push_valid);
    assign pop_fire   = bus.pop && !empty;
    assign accepted   = push_fire ? lane_total : '0;

    // One spare bit keeps the add-then-subtract free of intermediate wrap.
    assign cnt_wide = (CNT_W + 1)'(cnt) + (CNT_W + 1)'(accepted) - (CNT_W + 1)'(pop_fire);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement or process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_fire) wr_ptr <= wr_ptr + PTR_W'(lane_total);
            if (pop_fire)  rd_ptr <= rd_ptr + PTR_W'(1);
            cnt <= CNT_W'(cnt_wide);
        end
    end

    // NOTE: the storage array has no reset; contents are only meaningful once
    // written, and leaving it out of reset lets it map onto RAM/register files.
    always_ff @(posedge clk) begin
        if (push_fire && !bus.flush) begin
            for (int i = 0; i < PUSH_LANES; i++) begin
                if (bus.push_valid[i]) begin
                    mem[wr_ptr + PTR_W'(lane_offset[i])] <= bus.push_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign bus.pop_data    = mem[rd_ptr];
    assign bus.push_ready  = push_ready;
    assign bus.empty       = empty;
    assign bus.full        = (cnt == CNT_W'(DEPTH));
    assign bus.almost_full = (int'(cnt) >= AFULL_THRESH);
    assign bus.count       = cnt;
    assign bus.free_slots  = free_slots;

`ifdef MULTI_PUSH_FIFO_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] ovf_cnt;
    logic                 ovf_sticky;
    logic [OVF_CNT_W:0]   ovf_sum;

    // Lanes offered against backpressure; the carry bit drives saturation.
    assign ovf_sum = {1'b0, ovf_cnt} + (OVF_CNT_W + 1)'(lane_total);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt    <= '0;
            ovf_sticky <= 1'b0;
        end else if (bus.flush) begin
            ovf_cnt    <= '0;
            ovf_sticky <= 1'b0;
        end else if (!push_ready && (|bus.push_valid)) begin
            ovf_cnt    <= ovf_sum[OVF_CNT_W] ? '1 : ovf_sum[OVF_CNT_W-1:0];
            ovf_sticky <= 1'b1;
        end
    end

    assign bus.ovf_cnt    = ovf_cnt;
    assign bus.ovf_sticky = ovf_sticky;
`endif

endmodule

// File: tb/tb_multi_push_fifo.sv
// -----------------------------------------------------------------------------
// tb_multi_push_fifo
// Directed bench for multi_push_fifo (WIDTH=32, DEPTH=64, PUSH_LANES=4).
// Inputs change and outputs are sampled on the falling edge. A small queue
// model tracks expected contents; key points are also checked against
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_multi_push_fifo;

    localparam int W = 32;
    localparam int D = 64;
    localparam int L = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    multi_push_fifo_if #(.WIDTH(W), .DEPTH(D), .PUSH_LANES(L)) bus ();

    multi_push_fifo #(.WIDTH(W), .DEPTH(D), .PUSH_LANES(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] model_q[$];
    int unsigned  model_ovf    = 0;
    bit           model_sticky = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, update the model from pre-edge state, then
    // advance to the next falling edge and return inputs to idle.
    task automatic cycle(input logic [L-1:0] v,
                         input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input logic [W-1:0] d2, input logic [W-1:0] d3,
                         input logic p, input logic f);
        logic [W-1:0] d [L];
        bit           rdy;
        d = '{d0, d1, d2, d3};
        bus.push_valid = v;
        bus.push_data  = {d3, d2, d1, d0};
        bus.pop        = p;
        bus.flush      = f;
        if (f) begin
            model_q.delete();
            model_ovf    = 0;
            model_sticky = 1'b0;
        end else begin
            rdy = (D - model_q.size()) >= L;
            if (p && model_q.size() > 0) void'(model_q.pop_front());
            if (rdy) begin
                for (int i = 0; i < L; i++) if (v[i]) model_q.push_back(d[i]);
            end else if (v != '0) begin
                model_ovf += $countones(v);
                if (model_ovf > 32'hFFFF) model_ovf = 32'hFFFF;
                model_sticky = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        bus.push_valid = '0;
        bus.pop        = 1'b0;
        bus.flush      = 1'b0;
    endtask

    task automatic pop_one();
        cycle('0, '0, '0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic check_state(input string tag);
        int sz;
        sz = model_q.size();
        check({tag, ".count"}, 64'(bus.count), 64'(sz));
        check({tag, ".empty"}, 64'(bus.empty), 64'(sz == 0));
        check({tag, ".free"},  64'(bus.free_slots), 64'(D - sz));
        check({tag, ".ready"}, 64'(bus.push_ready), 64'((D - sz) >= L));
        if (sz > 0) check({tag, ".head"}, 64'(bus.pop_data), 64'(model_q[0]));
`ifdef MULTI_PUSH_FIFO_OVF_CNT_EN
        check({tag, ".ovf_cnt"},    64'(bus.ovf_cnt), 64'(model_ovf));
        check({tag, ".ovf_sticky"}, 64'(bus.ovf_sticky), 64'(model_sticky));
`endif
    endtask

    // Push n entries (4 per cycle, remainder on low lanes) with data base+k.
    task automatic push_n(input int n, input logic [W-1:0] base);
        int k;
        k = 0;
        while (k < n) begin
            logic [L-1:0] v;
            v = (n - k >= 4) ? 4'b1111 : L'((1 << (n - k)) - 1);
            cycle(v, base + W'(k), base + W'(k + 1), base + W'(k + 2), base + W'(k + 3), 1'b0, 1'b0);
            k += $countones(v);
        end
    endtask

    initial begin
        bus.push_valid = '0;
        bus.push_data  = '0;
        bus.pop        = 1'b0;
        bus.flush      = 1'b0;

        // Reset and idle
        repeat (2) @(negedge clk);
        check("rst.empty", 64'(bus.empty), 64'd1);
        check("rst.count", 64'(bus.count), 64'd0);
        check("rst.free",  64'(bus.free_slots), 64'd64);
        check("rst.ready", 64'(bus.push_ready), 64'd1);
        check("rst.full",  64'(bus.full), 64'd0);
        check("rst.afull", 64'(bus.almost_full), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_state("idle");

        // Sparse lanes 1011 compact to A,B,D
        cycle(4'b1011, 32'hA, 32'hB, 32'hC, 32'hD, 1'b0, 1'b0);
        check("cmp.count3", 64'(bus.count), 64'd3);
        check("cmp.headA",  64'(bus.pop_data), 64'hA);
        pop_one();
        check("cmp.headB",  64'(bus.pop_data), 64'hB);
        check("cmp.count2", 64'(bus.count), 64'd2);
        pop_one();
        check("cmp.headD",  64'(bus.pop_data), 64'hD);
        pop_one();
        check("cmp.count0", 64'(bus.count), 64'd0);
        check("cmp.empty",  64'(bus.empty), 64'd1);
        pop_one();
        check("pop_empty.count", 64'(bus.count), 64'd0);
        check_state("pop_empty");

        // Fill to 61: three free slots is not enough for an all-lanes push
        push_n(61, 32'h100);
        check("fill61.count", 64'(bus.count), 64'd61);
        check("fill61.ready", 64'(bus.push_ready), 64'd0);
        check("fill61.afull", 64'(bus.almost_full), 64'd1);
        check("fill61.free",  64'(bus.free_slots), 64'd3);
        cycle(4'b0001, 32'hDEAD, '0, '0, '0, 1'b0, 1'b0);
        check("bp.count", 64'(bus.count), 64'd61);
        check("bp.head",  64'(bus.pop_data), 64'h100);
        cycle(4'b0001, 32'hDEAD, '0, '0, '0, 1'b1, 1'b0);
        check("bp_pop.count", 64'(bus.count), 64'd60);
        check("bp_pop.ready", 64'(bus.push_ready), 64'd1);
        cycle(4'b0001, 32'hDEAD, '0, '0, '0, 1'b0, 1'b0);
        check("bp_acc.count", 64'(bus.count), 64'd61);
        check_state("bp_acc");
        for (int i = 0; i < 70 && model_q.size() > 0; i++) begin
            check("drain.head", 64'(bus.pop_data), 64'(model_q[0]));
            pop_one();
        end
        check("drain.empty", 64'(bus.empty), 64'd1);

        // Pointers now at 1; move them to 62 and push across the wrap
        push_n(61, 32'h200);
        for (int i = 0; i < 61; i++) pop_one();
        check("wrap.pre_ptr", 64'(dut.wr_ptr), 64'd62);
        cycle(4'b1111, 32'h57, 32'h58, 32'h59, 32'h5A, 1'b0, 1'b0);
        check("wrap.ptr",   64'(dut.wr_ptr), 64'd2);
        check("wrap.count", 64'(bus.count), 64'd4);
        check("wrap.W", 64'(bus.pop_data), 64'h57);
        pop_one();
        check("wrap.X", 64'(bus.pop_data), 64'h58);
        pop_one();
        check("wrap.Y", 64'(bus.pop_data), 64'h59);
        pop_one();
        check("wrap.Z", 64'(bus.pop_data), 64'h5A);
        pop_one();
        check("wrap.empty", 64'(bus.empty), 64'd1);

        // Simultaneous push+pop at 10, then flush overriding both
        push_n(10, 32'h300);
        check("pp.count10", 64'(bus.count), 64'd10);
        cycle(4'b0011, 32'h31, 32'h32, '0, '0, 1'b1, 1'b0);
        check("pp.count11", 64'(bus.count), 64'd11);
        check_state("pp");
        cycle(4'b0011, 32'h41, 32'h42, '0, '0, 1'b1, 1'b1);
        check("flush.count", 64'(bus.count), 64'd0);
        check("flush.empty", 64'(bus.empty), 64'd1);
        // Push with pop on empty: pop ignored, new data is the head next cycle
        cycle(4'b0001, 32'hE, '0, '0, '0, 1'b1, 1'b0);
        check("fwft.count", 64'(bus.count), 64'd1);
        check("fwft.head",  64'(bus.pop_data), 64'hE);
        pop_one();
        check_state("fwft_done");

        // Full FIFO, offered lanes blocked, pop at full, flush
        push_n(64, 32'h400);
        check("full.full",  64'(bus.full), 64'd1);
        check("full.ready", 64'(bus.push_ready), 64'd0);
        check("full.free",  64'(bus.free_slots), 64'd0);
        for (int i = 0; i < 3; i++) cycle(4'b1111, 32'h1, 32'h2, 32'h3, 32'h4, 1'b0, 1'b0);
        check("ovf.count", 64'(bus.count), 64'd64);
`ifdef MULTI_PUSH_FIFO_OVF_CNT_EN
        check("ovf.cnt12", 64'(bus.ovf_cnt), 64'd12);
        check("ovf.sticky", 64'(bus.ovf_sticky), 64'd1);
`endif
        check_state("ovf");
        pop_one();
        check("full_pop.count", 64'(bus.count), 64'd63);
        check("full_pop.full",  64'(bus.full), 64'd0);
        cycle('0, '0, '0, '0, '0, 1'b0, 1'b1);
        check("flush2.count", 64'(bus.count), 64'd0);
`ifdef MULTI_PUSH_FIFO_OVF_CNT_EN
        check("flush2.ovf_cnt", 64'(bus.ovf_cnt), 64'd0);
        check("flush2.sticky",  64'(bus.ovf_sticky), 64'd0);
`endif
        check_state("end");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
